// File: rtl/data_sram_resp.sv
// Data SRAM responder: 1-cycle read latency, byte-lane writes, sticky bounds error, saturating counters.
// Define DSRAM_WR_FWD_EN for write-first read data; the default build is read-first.
module data_sram_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        acc_err,
  output logic [31:0] acc_err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  logic [31:0]   off;
  logic [31:0]   word_idx;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic          is_write;

  // The >= BASE_ADDR term blocks addresses below the base from wrapping into range.
  assign off      = data_sram_addr - BASE_ADDR;
  assign word_idx = off >> 2;
  assign in_range = (data_sram_addr >= BASE_ADDR) && (word_idx < DEPTH);
  assign idx      = word_idx[AW-1:0];
  assign old_word = mem[idx];
  assign is_write = |data_sram_wen;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] resp_word;

`ifdef DSRAM_WR_FWD_EN
  always_comb begin
    resp_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (data_sram_wen[i]) resp_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end
`else
  assign resp_word = old_word;
`endif

  always_comb begin
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (data_sram_en) begin
      if (is_write) begin
        wr_cnt_d = (wr_cnt_q == 32'hFFFF_FFFF) ? wr_cnt_q : wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_d = (rd_cnt_q == 32'hFFFF_FFFF) ? rd_cnt_q : rd_cnt_q + 32'd1;
      end
      if (in_range) begin
        rdata_d = resp_word;
      end else begin
        rdata_d = 32'h0;
        if (!err_q) begin
          err_d      = 1'b1;
          err_addr_d = data_sram_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
      rd_cnt_q   <= 32'h0;
      wr_cnt_q   <= 32'h0;
    end else begin
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Kept free of a reset branch so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && data_sram_en && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign acc_err         = err_q;
  assign acc_err_addr    = err_addr_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;

endmodule
